// File: rtl/incubator_ctrl.sv
// Incubator climate controller: hysteretic heat/cool FSM with a three-speed
// cooler fan, sensor-timeout fault and a sticky out-of-range alarm.
module incubator_ctrl #(
    parameter int TEMP_W   = 8,
    parameter int HEAT_ON  = 15,
    parameter int HEAT_OFF = 30,
    parameter int COOL_ON  = 35,
    parameter int COOL_OFF = 25,
    parameter int FAN_UP1  = 40,
    parameter int FAN_UP2  = 45,
    parameter int FAN_DN1  = 35,
    parameter int FAN_DN2  = 40,
    parameter int ALARM_LO = -5,
    parameter int ALARM_HI = 55,
    parameter int DWELL    = 1,
    parameter int TIMEOUT  = 64
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic signed [TEMP_W-1:0] sensor,
    input  logic                     sensor_valid,
    input  logic                     alarm_clr,
    output logic                     heater,
    output logic                     cooler,
    output logic [3:0]               CRS,
    output logic                     alarm,
    output logic                     fault
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_HEAT  = 2'd1;
    localparam logic [1:0] ST_COOL  = 2'd2;
    localparam logic [1:0] ST_FAULT = 2'd3;

    localparam logic [1:0] FAN_S4 = 2'd0;
    localparam logic [1:0] FAN_S6 = 2'd1;
    localparam logic [1:0] FAN_S8 = 2'd2;

    localparam int TO_W = $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LIMIT  = TO_W'(TIMEOUT);
    localparam logic [3:0]      DWELL_LIM = 4'(DWELL);

    localparam logic signed [TEMP_W-1:0] T_HEAT_ON  = TEMP_W'(HEAT_ON);
    localparam logic signed [TEMP_W-1:0] T_HEAT_OFF = TEMP_W'(HEAT_OFF);
    localparam logic signed [TEMP_W-1:0] T_COOL_ON  = TEMP_W'(COOL_ON);
    localparam logic signed [TEMP_W-1:0] T_COOL_OFF = TEMP_W'(COOL_OFF);
    localparam logic signed [TEMP_W-1:0] T_FAN_UP1  = TEMP_W'(FAN_UP1);
    localparam logic signed [TEMP_W-1:0] T_FAN_UP2  = TEMP_W'(FAN_UP2);
    localparam logic signed [TEMP_W-1:0] T_FAN_DN1  = TEMP_W'(FAN_DN1);
    localparam logic signed [TEMP_W-1:0] T_FAN_DN2  = TEMP_W'(FAN_DN2);
    localparam logic signed [TEMP_W-1:0] T_ALARM_LO = TEMP_W'(ALARM_LO);
    localparam logic signed [TEMP_W-1:0] T_ALARM_HI = TEMP_W'(ALARM_HI);

    logic [1:0]      state, state_n;
    logic [1:0]      fan, fan_n;
    logic [3:0]      dwell, dwell_n;
    logic            dwell_cool, dwell_cool_n;
    logic [TO_W-1:0] to_cnt, to_n;
    logic [3:0]      dwell_inc;
    logic            want_heat, want_cool;

    assign want_heat = sensor < T_HEAT_ON;
    assign want_cool = sensor > T_COOL_ON;

    // A qualifying sample in the opposite direction restarts the run at one.
    assign dwell_inc = (dwell != 4'd0 && dwell_cool == want_cool) ? dwell + 4'd1 : 4'd1;

    // NOTE: every variable driven here gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_n      = state;
        fan_n        = fan;
        dwell_n      = dwell;
        dwell_cool_n = dwell_cool;
        to_n         = to_cnt;

        if (sensor_valid) begin
            to_n = '0;
            case (state)
                ST_IDLE: begin
                    if (want_heat || want_cool) begin
                        if (dwell_inc >= DWELL_LIM) begin
                            state_n = want_heat ? ST_HEAT : ST_COOL;
                        end else begin
                            dwell_n      = dwell_inc;
                            dwell_cool_n = want_cool;
                        end
                    end else begin
                        dwell_n = '0;
                    end
                end
                ST_HEAT: if (sensor > T_HEAT_OFF) state_n = ST_IDLE;
                ST_COOL: begin
                    if (sensor < T_COOL_OFF) begin
                        state_n = ST_IDLE;
                    end else begin
                        case (fan)
                            FAN_S4:  if (sensor > T_FAN_UP1) fan_n = FAN_S6;
                            FAN_S6:  if (sensor > T_FAN_UP2) fan_n = FAN_S8;
                                     else if (sensor < T_FAN_DN1) fan_n = FAN_S4;
                            FAN_S8:  if (sensor < T_FAN_DN2) fan_n = FAN_S6;
                            default: fan_n = FAN_S4;
                        endcase
                    end
                end
                default: state_n = ST_IDLE;  // leaving FAULT consumes the sample
            endcase
        end else begin
            if (to_cnt != TO_LIMIT) to_n = to_cnt + 1'b1;
            if (to_n == TO_LIMIT) state_n = ST_FAULT;
        end

        if (state_n != state) dwell_n = '0;
        if (state_n != ST_COOL) fan_n = FAN_S4;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= ST_IDLE;
            fan        <= FAN_S4;
            dwell      <= '0;
            dwell_cool <= 1'b0;
            to_cnt     <= '0;
        end else begin
            state      <= state_n;
            fan        <= fan_n;
            dwell      <= dwell_n;
            dwell_cool <= dwell_cool_n;
            to_cnt     <= to_n;
        end
    end

    // Set has priority over a simultaneous clear.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            alarm <= 1'b0;
        end else if (sensor_valid && (sensor < T_ALARM_LO || sensor > T_ALARM_HI)) begin
            alarm <= 1'b1;
        end else if (alarm_clr) begin
            alarm <= 1'b0;
        end
    end

    assign heater = (state == ST_HEAT);
    assign cooler = (state == ST_COOL);
    assign fault  = (state == ST_FAULT);

    always_comb begin
        CRS = 4'd0;
        if (state == ST_COOL) begin
            case (fan)
                FAN_S6:  CRS = 4'd6;
                FAN_S8:  CRS = 4'd8;
                default: CRS = 4'd4;
            endcase
        end
    end

endmodule

// File: tb/tb_incubator_ctrl.sv
// Directed self-checking bench for incubator_ctrl (default build plus a
// DWELL=3 build sharing the same stimulus).
module tb_incubator_ctrl;

    logic              clk = 1'b0;
    logic              rstn;
    logic signed [7:0] sensor;
    logic              sensor_valid;
    logic              alarm_clr;

    logic       heater, cooler, alarm, fault;
    logic [3:0] crs;
    logic       heater3, cooler3, alarm3, fault3;
    logic [3:0] crs3;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    incubator_ctrl dut (
        .clk(clk), .rstn(rstn), .sensor(sensor), .sensor_valid(sensor_valid),
        .alarm_clr(alarm_clr), .heater(heater), .cooler(cooler), .CRS(crs),
        .alarm(alarm), .fault(fault)
    );

    incubator_ctrl #(.DWELL(3)) dut3 (
        .clk(clk), .rstn(rstn), .sensor(sensor), .sensor_valid(sensor_valid),
        .alarm_clr(alarm_clr), .heater(heater3), .cooler(cooler3), .CRS(crs3),
        .alarm(alarm3), .fault(fault3)
    );

    // Drive one cycle of inputs, then sample outputs 1 time unit after the edge.
    task automatic apply(input logic signed [7:0] s, input logic v, input logic clr);
        sensor       = s;
        sensor_valid = v;
        alarm_clr    = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        apply(8'sd0, 1'b0, 1'b0);
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        apply(8'sd60, 1'b1, 1'b0);
        checks++;
        if ({heater, cooler, crs, alarm, fault} !== 8'h00) begin
            errors++;
            $display("FAIL reset_main got h=%b c=%b crs=%0d a=%b f=%b want all 0",
                     heater, cooler, crs, alarm, fault);
        end
        checks++;
        if ({heater3, cooler3, crs3, alarm3, fault3} !== 8'h00) begin
            errors++;
            $display("FAIL reset_dwell3 got h=%b c=%b crs=%0d a=%b f=%b want all 0",
                     heater3, cooler3, crs3, alarm3, fault3);
        end
        rstn = 1'b1;
    endtask

    task automatic test_ramp_up();
        logic       exp_h, exp_c;
        logic [3:0] exp_crs;
        do_reset();
        for (int s = -10; s <= 60; s++) begin
            apply(8'(s), 1'b1, 1'b0);
            exp_h   = (s <= 30);
            exp_c   = (s >= 36);
            exp_crs = (s >= 46) ? 4'd8 : (s >= 41) ? 4'd6 : (s >= 36) ? 4'd4 : 4'd0;
            checks++;
            if (heater !== exp_h || cooler !== exp_c || crs !== exp_crs) begin
                errors++;
                $display("FAIL ramp_up s=%0d got h=%b c=%b crs=%0d want h=%b c=%b crs=%0d",
                         s, heater, cooler, crs, exp_h, exp_c, exp_crs);
            end
        end
        checks++;
        if (alarm !== 1'b1) begin
            errors++;
            $display("FAIL ramp_up_alarm got %b want 1", alarm);
        end
    endtask

    // Continues from the COOL/S8 state left by test_ramp_up.
    task automatic test_ramp_down();
        logic       exp_h, exp_c;
        logic [3:0] exp_crs;
        for (int s = 60; s >= -10; s--) begin
            apply(8'(s), 1'b1, 1'b0);
            exp_h   = (s <= 14);
            exp_c   = (s >= 25);
            exp_crs = (s >= 40) ? 4'd8 : (s >= 35) ? 4'd6 : (s >= 25) ? 4'd4 : 4'd0;
            checks++;
            if (heater !== exp_h || cooler !== exp_c || crs !== exp_crs) begin
                errors++;
                $display("FAIL ramp_down s=%0d got h=%b c=%b crs=%0d want h=%b c=%b crs=%0d",
                         s, heater, cooler, crs, exp_h, exp_c, exp_crs);
            end
        end
    endtask

    task automatic test_dwell();
        logic signed [7:0] seq [6];
        logic              exp_c3 [6];
        seq    = '{8'sd36, 8'sd36, 8'sd20, 8'sd36, 8'sd36, 8'sd36};
        exp_c3 = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            apply(seq[i], 1'b1, 1'b0);
            checks++;
            if (cooler3 !== exp_c3[i]) begin
                errors++;
                $display("FAIL dwell3 sample=%0d got cooler=%b want %b", i, cooler3, exp_c3[i]);
            end
            if (i == 0) begin
                checks++;
                if (cooler !== 1'b1) begin
                    errors++;
                    $display("FAIL dwell1_first got cooler=%b want 1", cooler);
                end
            end
            apply(8'sd0, 1'b0, 1'b0);
            apply(8'sd0, 1'b0, 1'b0);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        apply(8'sd40, 1'b1, 1'b0);
        checks++;
        if (cooler !== 1'b1 || crs !== 4'd4) begin
            errors++;
            $display("FAIL timeout_cool_entry got c=%b crs=%0d want c=1 crs=4", cooler, crs);
        end
        for (int i = 0; i < 63; i++) apply(8'sd40, 1'b0, 1'b0);
        checks++;
        if (fault !== 1'b0 || cooler !== 1'b1) begin
            errors++;
            $display("FAIL timeout_63 got f=%b c=%b want f=0 c=1", fault, cooler);
        end
        apply(8'sd40, 1'b0, 1'b0);
        checks++;
        if (fault !== 1'b1 || cooler !== 1'b0 || crs !== 4'd0 || heater !== 1'b0) begin
            errors++;
            $display("FAIL timeout_64 got f=%b c=%b crs=%0d h=%b want f=1 c=0 crs=0 h=0",
                     fault, cooler, crs, heater);
        end
        apply(8'sd20, 1'b1, 1'b0);
        checks++;
        if (fault !== 1'b0 || heater !== 1'b0 || cooler !== 1'b0) begin
            errors++;
            $display("FAIL fault_exit got f=%b h=%b c=%b want f=0 h=0 c=0", fault, heater, cooler);
        end
        // Second fault: the exit sample must not count toward IDLE->HEAT.
        for (int i = 0; i < 64; i++) apply(8'sd0, 1'b0, 1'b0);
        checks++;
        if (fault !== 1'b1) begin
            errors++;
            $display("FAIL timeout_again got f=%b want 1", fault);
        end
        apply(8'sd10, 1'b1, 1'b0);
        checks++;
        if (fault !== 1'b0 || heater !== 1'b0) begin
            errors++;
            $display("FAIL fault_exit_no_eval got f=%b h=%b want f=0 h=0", fault, heater);
        end
        apply(8'sd10, 1'b1, 1'b0);
        checks++;
        if (heater !== 1'b1) begin
            errors++;
            $display("FAIL fault_then_heat got h=%b want 1", heater);
        end
        // Reset while in FAULT overrides a valid sample.
        for (int i = 0; i < 64; i++) apply(8'sd0, 1'b0, 1'b0);
        rstn = 1'b0;
        apply(8'sd10, 1'b1, 1'b0);
        rstn = 1'b1;
        checks++;
        if (fault !== 1'b0 || heater !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_fault got f=%b h=%b want f=0 h=0", fault, heater);
        end
    endtask

    task automatic test_alarm();
        do_reset();
        apply(8'sd20, 1'b1, 1'b0);
        apply(8'sd56, 1'b1, 1'b1);
        checks++;
        if (alarm !== 1'b1 || cooler !== 1'b1 || heater !== 1'b0) begin
            errors++;
            $display("FAIL alarm_set_wins got a=%b c=%b h=%b want a=1 c=1 h=0", alarm, cooler, heater);
        end
        apply(8'sd20, 1'b1, 1'b1);
        checks++;
        if (alarm !== 1'b0 || cooler !== 1'b0 || heater !== 1'b0) begin
            errors++;
            $display("FAIL alarm_clear got a=%b c=%b h=%b want a=0 c=0 h=0", alarm, cooler, heater);
        end
        apply(8'sd55, 1'b1, 1'b0);
        checks++;
        if (alarm !== 1'b0) begin
            errors++;
            $display("FAIL alarm_hi_edge got %b want 0", alarm);
        end
        apply(-8'sd5, 1'b1, 1'b0);
        checks++;
        if (alarm !== 1'b0) begin
            errors++;
            $display("FAIL alarm_lo_edge got %b want 0", alarm);
        end
        apply(-8'sd6, 1'b1, 1'b0);
        checks++;
        if (alarm !== 1'b1 || heater !== 1'b1) begin
            errors++;
            $display("FAIL alarm_lo_set got a=%b h=%b want a=1 h=1", alarm, heater);
        end
        apply(8'sd0, 1'b0, 1'b1);
        checks++;
        if (alarm !== 1'b0 || heater !== 1'b1) begin
            errors++;
            $display("FAIL alarm_clr_novalid got a=%b h=%b want a=0 h=1", alarm, heater);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        apply(8'sd10, 1'b1, 1'b0);
        checks++;
        if (heater !== 1'b1) begin
            errors++;
            $display("FAIL mid_heat got h=%b want 1", heater);
        end
        rstn = 1'b0;
        apply(8'sd10, 1'b1, 1'b0);
        rstn = 1'b1;
        checks++;
        if (heater !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset got h=%b want 0", heater);
        end
        apply(8'sd10, 1'b1, 1'b0);
        checks++;
        if (heater !== 1'b1) begin
            errors++;
            $display("FAIL mid_recover got h=%b want 1", heater);
        end
    endtask

    initial begin
        rstn         = 1'b0;
        sensor       = '0;
        sensor_valid = 1'b0;
        alarm_clr    = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_ramp_up();
        test_ramp_down();
        test_dwell();
        test_timeout();
        test_alarm();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
